mem_bus_ctrl: RTL and testbench

Parametrised memory-stage bus controller for the pipelined CPU. It takes the MEM-stage load/store request, decodes the address onto one of `NUM_SLAVES` memory-mapped slaves (data RAM, peripherals, UART, ...) and runs a ready/wait-state handshake with the selected slave. While a transfer is outstanding it stalls the pipeline, and it returns registered read data plus a bus-error flag. It replaces the fixed OR-combining of slave read buses with a decoded, multi-cycle-capable interconnect.

---
 rtl/mem_bus_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus controller: decodes MEM-stage loads/stores onto NUM_SLAVES slaves with a
// ready/wait handshake. Optional WAIT timeout is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int unsigned                    NUM_SLAVES = 4,
  parameter int unsigned                    DATA_W     = 32,
  parameter int unsigned                    ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_BASE = {32'h40000200, 32'h40000100,
                                                          32'h40000000, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_MASK = {32'hFFFFFF00, 32'hFFFFFF00,
                                                          32'hFFFFFF00, 32'hC0000000},
  parameter int unsigned                    TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MemRead_mem,
  input  logic                         MemWrite_mem,
  input  logic [ADDR_W-1:0]            ALUResult_mem,
  input  logic [DATA_W-1:0]            MemWriteData_mem,
  output logic                         stall,
  output logic [DATA_W-1:0]            MemReadData,
  output logic                         rvalid,
  output logic                         bus_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_rd,
  output logic                         s_wr,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT < 1) begin : g_param_check
    $error("mem_bus_ctrl: NUM_SLAVES must be 1..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e state_q;

  logic                  req;
  logic                  hit;
  logic [NUM_SLAVES-1:0] hit_onehot;
  logic                  sel_ready;
  logic [DATA_W-1:0]     sel_rdata;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned       CntW     = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0]   WaitLast = CntW'(TIMEOUT - 1);
  logic [CntW-1:0] wait_cnt_q;
`endif

  assign req   = MemRead_mem | MemWrite_mem;
  assign stall = ((state_q == StIdle) & req) | (state_q == StWait);

  // Scan from the top index down so the lowest-index match is the one left standing.
  always_comb begin
    hit        = 1'b0;
    hit_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((ALUResult_mem & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        hit           = 1'b1;
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
      end
    end
  end

  // s_sel is one-hot in WAIT, so OR-ing the gated slices is a clean mux.
  always_comb begin
    sel_ready = |(s_ready & s_sel);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_sel[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      s_sel       <= '0;
      s_rd        <= 1'b0;
      s_wr        <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      MemReadData <= '0;
      rvalid      <= 1'b0;
      bus_err     <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            s_addr  <= ALUResult_mem;
            s_wdata <= MemWriteData_mem;
            if (hit) begin
              s_sel   <= hit_onehot;
              s_wr    <= MemWrite_mem;
              s_rd    <= MemRead_mem & ~MemWrite_mem;
              state_q <= StWait;
`ifdef MEM_BUS_TIMEOUT_EN
              wait_cnt_q <= '0;
`endif
            end else begin
              MemReadData <= '0;
              bus_err     <= 1'b1;
              rvalid      <= 1'b1;
              state_q     <= StDone;
            end
          end
        end
        StWait: begin
          if (sel_ready) begin
            MemReadData <= s_wr ? '0 : sel_rdata;
            s_sel       <= '0;
            s_rd        <= 1'b0;
            s_wr        <= 1'b0;
            bus_err     <= 1'b0;
            rvalid      <= 1'b1;
            state_q     <= StDone;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          else if (wait_cnt_q == WaitLast) begin
            MemReadData <= '0;
            s_sel       <= '0;
            s_rd        <= 1'b0;
            s_wr        <= 1'b0;
            bus_err     <= 1'b1;
            rvalid      <= 1'b1;
            state_q     <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
`endif
        end
        StDone: begin
          rvalid  <= 1'b0;
          bus_err <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed cases plus random transactions scored against
// a transaction-level latency/decode model.
module tb_mem_bus_ctrl;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 15;

  localparam logic [31:0] REF_BASE [NS] = '{32'h00000000, 32'h40000000, 32'h40000100,
                                            32'h40000200};
  localparam logic [31:0] REF_MASK [NS] = '{32'hC0000000, 32'hFFFFFF00, 32'hFFFFFF00,
                                            32'hFFFFFF00};

  logic              clk = 1'b0;
  logic              reset;
  logic              MemRead_mem, MemWrite_mem;
  logic [AW-1:0]     ALUResult_mem;
  logic [DW-1:0]     MemWriteData_mem;
  logic              stall, rvalid, bus_err, s_rd, s_wr;
  logic [DW-1:0]     MemReadData, s_wdata;
  logic [NS-1:0]     s_sel, s_ready;
  logic [AW-1:0]     s_addr;
  logic [NS*DW-1:0]  s_rdata;
  logic [DW-1:0]     slave_data [NS];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NS; g++) begin : g_rdata
    assign s_rdata[g*DW +: DW] = slave_data[g];
  end

  mem_bus_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .MemRead_mem      (MemRead_mem),
    .MemWrite_mem     (MemWrite_mem),
    .ALUResult_mem    (ALUResult_mem),
    .MemWriteData_mem (MemWriteData_mem),
    .stall            (stall),
    .MemReadData      (MemReadData),
    .rvalid           (rvalid),
    .bus_err          (bus_err),
    .s_sel            (s_sel),
    .s_rd             (s_rd),
    .s_wr             (s_wr),
    .s_addr           (s_addr),
    .s_wdata          (s_wdata),
    .s_rdata          (s_rdata),
    .s_ready          (s_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_target(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & REF_MASK[i]) == REF_BASE[i]) return i;
    end
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One access from IDLE to completion; delay = number of WAIT cycles the target holds ready low.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input bit noise);
    int tgt, lat, fails0;
    bit err;
    logic [NS-1:0] oh;
    logic [31:0] exp_rdata;
    fails0 = failures;
    for (int i = 0; i < NS; i++) slave_data[i] = $urandom;
    tgt = ref_target(addr);
    err = 1'b0;
    if (tgt < 0) begin
      lat = 1;
      err = 1'b1;
    end else begin
      lat = delay + 2;
`ifdef MEM_BUS_TIMEOUT_EN
      if (delay >= TO) begin
        lat = TO + 1;
        err = 1'b1;
      end
`endif
    end
    oh = (tgt < 0) ? '0 : NS'(1) << tgt;
    exp_rdata = (err || wr) ? 32'h0 : slave_data[tgt];
    MemRead_mem      = rd;
    MemWrite_mem     = wr;
    ALUResult_mem    = addr;
    MemWriteData_mem = wdata;
    for (int c = 0; c <= lat; c++) begin
      s_ready = noise ? NS'($urandom) : '0;
      if (tgt >= 0) s_ready[tgt] = (c >= 1) && (c - 1 >= delay);
      @(negedge clk);
      if (c < lat) begin
        check_eq("stall_busy", stall, 1'b1);
        check_eq("rvalid_early", rvalid, 1'b0);
        if (c >= 1) begin
          check_eq("wait_sel", s_sel, oh);
          check_eq("wait_wr", s_wr, wr);
          check_eq("wait_rd", s_rd, rd & ~wr);
          check_eq("wait_addr", s_addr, addr);
          check_eq("wait_wdata", s_wdata, wdata);
        end
      end else begin
        check_eq("done_rvalid", rvalid, 1'b1);
        check_eq("done_stall", stall, 1'b0);
        check_eq("done_err", bus_err, err);
        check_eq("done_rdata", MemReadData, exp_rdata);
        check_eq("done_sel", s_sel, '0);
        check_eq("done_strobes", {s_rd, s_wr}, 2'b00);
      end
      next_cycle();
    end
    MemRead_mem  = 1'b0;
    MemWrite_mem = 1'b0;
    s_ready      = '0;
    if (failures != fails0) begin
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, delay, kind;
    bit rd, wr;
    logic [31:0] addr;
    reset            = 1'b1;
    MemRead_mem      = 1'b0;
    MemWrite_mem     = 1'b0;
    ALUResult_mem    = '0;
    MemWriteData_mem = '0;
    s_ready          = '0;
    for (int i = 0; i < NS; i++) slave_data[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_sel", s_sel, '0);
    check_eq("rst_strobes", {s_rd, s_wr}, 2'b00);
    check_eq("rst_addr", s_addr, '0);
    check_eq("rst_wdata", s_wdata, '0);
    check_eq("rst_rdata", MemReadData, '0);
    check_eq("rst_flags", {rvalid, bus_err, stall}, 3'b000);
    next_cycle();
    reset = 1'b0;

    // Directed cases.
    run_txn(1'b1, 1'b0, 32'h00000010, 32'h0, 0, 1'b0);
    run_txn(1'b0, 1'b1, 32'h40000104, 32'h12345678, 3, 1'b1);
    run_txn(1'b1, 1'b0, 32'h80000000, 32'h0, 0, 1'b0);
    run_txn(1'b1, 1'b1, 32'h40000000, 32'hCAFEF00D, 1, 1'b1);
    @(negedge clk);
    check_eq("idle_stall", stall, 1'b0);
    next_cycle();

`ifdef MEM_BUS_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 32'h40000008, 32'h0, 1000, 1'b0);
    run_txn(1'b1, 1'b0, 32'h4000000C, 32'h0, TO - 1, 1'b1);
`else
    MemRead_mem   = 1'b1;
    ALUResult_mem = 32'h40000008;
    n = 0;
    repeat (120) begin
      @(negedge clk);
      if (stall) n++;
      next_cycle();
    end
    check_eq("stall_hold", n, 120);
    MemRead_mem = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
`endif

    // Reset in the second WAIT cycle of a slave-3 write.
    MemWrite_mem     = 1'b1;
    ALUResult_mem    = 32'h40000210;
    MemWriteData_mem = 32'hA5A5A5A5;
    next_cycle();
    @(negedge clk);
    check_eq("rst_wait_sel", s_sel, 4'b1000);
    next_cycle();
    reset        = 1'b1;
    MemWrite_mem = 1'b0;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_eq("after_rst_sel", s_sel, '0);
    check_eq("after_rst_stall", stall, 1'b0);
    check_eq("after_rst_rvalid", rvalid, 1'b0);
    check_eq("after_rst_wr", s_wr, 1'b0);
    next_cycle();

    // Random transactions.
    repeat (60) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      if ($urandom_range(0, 1) == 0) addr = $urandom;
      else addr = REF_BASE[$urandom_range(0, NS - 1)] | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) addr = 32'h40000300 | 32'($urandom_range(0, 255));
      delay = $urandom_range(0, 4);
`ifdef MEM_BUS_TIMEOUT_EN
      if ($urandom_range(0, 5) == 0) delay = $urandom_range(TO - 2, TO + 2);
`endif
      run_txn(rd, wr, addr, $urandom, delay, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("gap_stall", stall, 1'b0);
        next_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
